qpsk_mod: RTL and testbench

Transmit-side QPSK modulator core: packs incoming 32-bit bit-words into 16 dibit symbols and maps each dibit to a ±amp I/Q point. Each point is held for `sps` output samples, so every sample leaves as a 32-bit {I,Q} word. It sits in the modulator RFNoC block between the axi_wrapper `m_axis_data` (bits in) and `s_axis_data` (samples out). It is the counterpart of the Costas/BitSync demodulator chain. CVITA header and length handling stay in the wrapper.

---
 rtl/qpsk_pkg.sv | 31 +++
 rtl/qpsk_symbol_map.sv | 28 ++
 rtl/qpsk_mod.sv | 114 +++++++++++
 tb/tb_qpsk_mod.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// QPSK modulator shared definitions.
// Constants, FSM states and the dibit sign mapping.
package qpsk_pkg;

  localparam int SYMS_PER_WORD = 16;
  localparam int BITS_PER_SYM  = 2;
  localparam int SYM_W         = $clog2(SYMS_PER_WORD);

  localparam int SR_QPSK_MODE  = 128;
  localparam int SR_QPSK_SPS   = 129;
  localparam int SR_QPSK_AMP   = 130;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic i_neg;
    logic q_neg;
  } sign_t;

  // {b1,b0}: b1 selects the I sign, b0 the Q sign
  function automatic sign_t dibit_sign(input logic [1:0] d);
    sign_t s;
    s.i_neg = d[1];
    s.q_neg = d[0];
    return s;
  endfunction

endpackage

// File: rtl/qpsk_symbol_map.sv
// Dibit to I/Q constellation point.
// Magnitude is zero-extended to 16 bits before negation.
module qpsk_symbol_map
  import qpsk_pkg::*;
#(
  parameter int AMP_W = 15
) (
  input  logic [1:0]       dibit,
  input  logic [AMP_W-1:0] amp,
  output logic [15:0]      i_val,
  output logic [15:0]      q_val
);

  logic [15:0] mag;
  logic [15:0] neg;
  sign_t       sgn;

  assign mag = 16'(amp);
  assign neg = 16'(-mag);
  assign sgn = dibit_sign(dibit);

  // pick positive or negated magnitude per axis
  always_comb begin
    i_val = sgn.i_neg ? neg : mag;
    q_val = sgn.q_neg ? neg : mag;
  end

endmodule

// File: rtl/qpsk_mod.sv
// QPSK modulator: 32-bit words -> 16 symbols,
// each held for sps samples as {I,Q}.
module qpsk_mod
  import qpsk_pkg::*;
#(
  parameter int SPS_W = 8,
  parameter int AMP_W = 15
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic [SPS_W-1:0] sps,
  input  logic [AMP_W-1:0] amp,
  input  logic [31:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [31:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS_PER_WORD - 1);
  localparam logic [SPS_W-1:0] SPS_ONE  = SPS_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [31:0]      wd;
  logic             wlast;
  logic [SYM_W-1:0] sym;
  logic [SPS_W-1:0] smp;
  logic [SPS_W-1:0] sps_l;
  logic [AMP_W-1:0] amp_l;

  logic             busy;
  logic             last_smp;
  logic             last_sym;
  logic             word_end;
  logic             o_hs;
  logic             load;
  logic [SPS_W-1:0] sps_in;
  logic [4:0]       bit_hi;
  logic [1:0]       dibit;
  logic [15:0]      i_val;
  logic [15:0]      q_val;

  assign busy     = (state == S_RUN);
  assign last_smp = (smp == sps_l - SPS_ONE);
  assign last_sym = (sym == SYM_LAST);
  assign word_end = busy & last_sym & last_smp;
  assign o_hs     = busy & o_tready;
  assign i_tready = ~busy | (word_end & o_tready);
  assign load     = i_tvalid & i_tready;
  assign sps_in   = (sps == '0) ? SPS_ONE : sps;

  // MSB-first dibit selection
  assign bit_hi = 5'd31 - {sym, 1'b0};
  assign dibit  = wd[bit_hi -: 2];

  qpsk_symbol_map #(
    .AMP_W(AMP_W)
  ) u_map (
    .dibit(dibit),
    .amp  (amp_l),
    .i_val(i_val),
    .q_val(q_val)
  );

  assign o_tvalid = busy;
  assign o_tlast  = word_end & wlast;
  assign o_tdata  = busy ? {i_val, q_val} : 32'd0;

  // next state: load from idle, drop to idle after last sample
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (load) state_nx = S_RUN;
      S_RUN:  if (o_hs & word_end & ~load) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state, word latch and symbol/sample counters
  always_ff @(posedge ce_clk) begin
    if (ce_rst | clear) begin
      state <= S_IDLE;
      wd    <= '0;
      wlast <= 1'b0;
      sym   <= '0;
      smp   <= '0;
      sps_l <= SPS_ONE;
      amp_l <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        wd    <= i_tdata;
        wlast <= i_tlast;
        sps_l <= sps_in;
        amp_l <= amp;
        sym   <= '0;
        smp   <= '0;
      end else if (o_hs) begin
        if (last_smp) begin
          smp <= '0;
          sym <= sym + 1'b1;
        end else begin
          smp <= smp + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_mod.sv
// Self-checking bench for qpsk_mod.
// Randomized traffic against a queue-based sample model.
module tb_qpsk_mod;

  localparam int SPS_W = 8;
  localparam int AMP_W = 15;

  logic             ce_clk;
  logic             ce_rst;
  logic             clear;
  logic [SPS_W-1:0] sps;
  logic [AMP_W-1:0] amp;
  logic [31:0]      i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic [31:0]      o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  qpsk_mod #(
    .SPS_W(SPS_W),
    .AMP_W(AMP_W)
  ) dut (
    .ce_clk  (ce_clk),
    .ce_rst  (ce_rst),
    .clear   (clear),
    .sps     (sps),
    .amp     (amp),
    .i_tdata (i_tdata),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  initial ce_clk = 1'b0;
  always #5 ce_clk = ~ce_clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } samp_t;

  samp_t       exp_q[$];
  logic [31:0] obs_d[$];
  int          hs_cyc[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          n_last     = 0;
  int          last_at    = 0;
  int          cyc        = 0;
  bit          rnd_rdy    = 0;
  bit          held       = 0;
  logic [31:0] held_d;
  logic        held_l;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expand one accepted word into its expected sample stream
  task automatic push_word(input logic [31:0] w, input logic l,
                           input int s, input int a);
    int    se;
    int    iv;
    int    qv;
    samp_t e;
    se = (s == 0) ? 1 : s;
    for (int k = 0; k < 16; k++) begin
      iv = w[31 - 2*k] ? -a : a;
      qv = w[30 - 2*k] ? -a : a;
      for (int j = 0; j < se; j++) begin
        e.d = {16'(iv), 16'(qv)};
        e.l = l && (k == 15) && (j == se - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // monitor: compare every output handshake, track stalls
  always @(negedge ce_clk) begin
    samp_t e;
    cyc++;
    if (ce_rst || clear) begin
      exp_q.delete();
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", o_tvalid, 1);
        check("hold_data", o_tdata, held_d);
        check("hold_last", o_tlast, held_l);
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample", o_tdata, e.d);
          check("tlast", o_tlast, e.l);
        end
        if (o_tlast) begin
          check("rdy_on_last", i_tready, 1);
          n_last++;
        end
        obs_d.push_back(o_tdata);
        hs_cyc.push_back(cyc);
        if (o_tlast) last_at = obs_d.size();
      end
      held   = o_tvalid && !o_tready;
      held_d = o_tdata;
      held_l = o_tlast;
      if (i_tvalid && i_tready)
        push_word(i_tdata, i_tlast, int'(sps), int'(amp));
    end
  end

  always @(posedge ce_clk) begin
    if (rnd_rdy) begin
      #1;
      o_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [31:0] w, input logic l);
    i_tdata  = w;
    i_tlast  = l;
    i_tvalid = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge ce_clk);
      if (i_tready) begin
        @(posedge ce_clk);
        #1;
        i_tvalid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    i_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 8000; t++) begin
      @(negedge ce_clk);
      if (exp_q.size() == 0 && !o_tvalid) begin
        @(posedge ce_clk);
        #1;
        return;
      end
    end
    check("drain_timeout", 1, 0);
  endtask

  int base;
  int lb;
  int bad;

  initial begin
    ce_rst   = 1'b1;
    clear    = 1'b0;
    sps      = 8'd1;
    amp      = '0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b0;

    // reset
    repeat (3) @(posedge ce_clk);
    #1;
    check("rst_valid", o_tvalid, 0);
    check("rst_data", o_tdata, 0);
    check("rst_last", o_tlast, 0);
    ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;
    check("rst_ready", i_tready, 1);

    // mapping
    sps = 8'd1; amp = 15'h4000; o_tready = 1'b1;
    base = obs_d.size(); lb = n_last;
    send_word(32'h1B1B_1B1B, 1'b1);
    wait_drain();
    check("map_count", obs_d.size() - base, 16);
    check("map_nlast", n_last - lb, 1);
    check("map_last_at", last_at - base, 16);
    check("map_s0", obs_d[base + 0], 32'h4000_4000);
    check("map_s1", obs_d[base + 1], 32'h4000_C000);
    check("map_s2", obs_d[base + 2], 32'hC000_4000);
    check("map_s3", obs_d[base + 3], 32'hC000_C000);
    check("map_s15", obs_d[base + 15], 32'hC000_C000);

    // upsample and throughput
    sps = 8'd4;
    base = obs_d.size(); lb = n_last;
    send_word(32'h0000_0000, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b1);
    wait_drain();
    check("ups_count", obs_d.size() - base, 128);
    check("ups_nlast", n_last - lb, 1);
    check("ups_last_at", last_at - base, 128);
    check("ups_s63", obs_d[base + 63], 32'h4000_4000);
    check("ups_s64", obs_d[base + 64], 32'hC000_C000);
    check("ups_span", hs_cyc[base + 127] - hs_cyc[base], 127);

    // backpressure with random traffic
    sps = 8'd3; amp = 15'h7FFF; rnd_rdy = 1;
    base = obs_d.size();
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge ce_clk);
      #1;
      send_word($urandom, 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rnd_rdy = 0;
    @(posedge ce_clk);
    #2;
    o_tready = 1'b1;
    check("bp_count", obs_d.size() - base, 8 * 48);
    bad = 0;
    for (int i = base; i < obs_d.size(); i++) begin
      if (!(obs_d[i][31:16] inside {16'h7FFF, 16'h8001})) bad++;
      if (!(obs_d[i][15:0] inside {16'h7FFF, 16'h8001})) bad++;
    end
    check("bp_extremes", bad, 0);

    // config latch
    sps = 8'd2; amp = 15'h1234;
    base = obs_d.size();
    send_word(32'h0F0F_A5A5, 1'b1);
    repeat (5) @(posedge ce_clk);
    #1;
    sps = 8'd5;
    send_word(32'h3C3C_5A5A, 1'b1);
    wait_drain();
    check("cfg_count", obs_d.size() - base, 32 + 80);
    check("cfg_span", hs_cyc[base + 31] - hs_cyc[base], 31);
    sps = 8'd0;
    base = obs_d.size();
    send_word(32'h9876_5432, 1'b1);
    wait_drain();
    check("sps0_count", obs_d.size() - base, 16);

    // clear mid-word
    sps = 8'd1; amp = 15'h4000;
    base = obs_d.size(); lb = n_last;
    send_word(32'hFFFF_FFFF, 1'b1);
    for (int t = 0; t < 100; t++) begin
      @(posedge ce_clk);
      #1;
      if (obs_d.size() - base >= 7) break;
    end
    clear = 1'b1;
    @(posedge ce_clk);
    #1;
    clear = 1'b0;
    check("clr_valid", o_tvalid, 0);
    check("clr_count", obs_d.size() - base, 7);
    check("clr_nlast", n_last - lb, 0);
    send_word(32'h1B1B_1B1B, 1'b1);
    wait_drain();
    check("clr_restart", obs_d[base + 7], 32'h4000_4000);
    check("clr_total", obs_d.size() - base, 23);
    check("clr_nlast2", n_last - lb, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
